// File: rtl/eu_dispatch_arbiter.sv
// Round-robin arbiter that shares one execution unit between several operand collectors,
// registering the winning instruction into a single valid/ready output stage.
module eu_dispatch_arbiter #(
  parameter int unsigned NumCollectors   = 4,
  parameter int unsigned RegWidth        = 32,
  parameter int unsigned WarpWidth       = 4,
  parameter int unsigned OperandsPerInst = 2,
  parameter type iid_t       = logic,
  parameter type reg_idx_t   = logic,
  parameter type warp_data_t = logic [RegWidth*WarpWidth-1:0],
  parameter type coll_idx_t  = logic [(NumCollectors > 1 ? $clog2(NumCollectors) : 1)-1:0]
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic                                             clr_i,
  input  logic       [NumCollectors-1:0]                   opc_valid_i,
  output logic       [NumCollectors-1:0]                   opc_ready_o,
  input  iid_t       [NumCollectors-1:0]                   opc_tag_i,
  input  reg_idx_t   [NumCollectors-1:0]                   opc_dst_i,
  input  warp_data_t [NumCollectors-1:0][OperandsPerInst-1:0] opc_operands_i,
  output logic                                             eu_valid_o,
  input  logic                                             eu_ready_i,
  output iid_t                                             eu_tag_o,
  output reg_idx_t                                         eu_dst_o,
  output warp_data_t [OperandsPerInst-1:0]                 eu_operands_o,
  output coll_idx_t                                        eu_src_o
);

  logic                              valid_q;
  iid_t                              tag_q;
  reg_idx_t                          dst_q;
  warp_data_t [OperandsPerInst-1:0]  operands_q;
  coll_idx_t                         src_q;
  coll_idx_t                         rr_q, rr_d;

  logic      load_en;
  logic      grant_exists;
  coll_idx_t grant_idx;
  logic      handshake;

  assign load_en = !valid_q || eu_ready_i;

  // Rotating priority search starting at rr_q.
  always_comb begin
    grant_exists = 1'b0;
    grant_idx    = '0;
    for (int unsigned i = 0; i < NumCollectors; i++) begin
      automatic int unsigned cand = (32'(rr_q) + i) % NumCollectors;
      if (!grant_exists && opc_valid_i[coll_idx_t'(cand)]) begin
        grant_exists = 1'b1;
        grant_idx    = coll_idx_t'(cand);
      end
    end
  end

  assign rr_d = coll_idx_t'((32'(grant_idx) + 32'd1) % NumCollectors);

  always_comb begin
    opc_ready_o = '0;
    if (grant_exists && load_en && !clr_i && !rst_i) begin
      opc_ready_o[grant_idx] = 1'b1;
    end
  end

  // Ready is only ever raised on a valid requester, so any ready bit is a handshake.
  assign handshake = |opc_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      tag_q      <= '0;
      dst_q      <= '0;
      operands_q <= '0;
      src_q      <= '0;
      rr_q       <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (load_en) begin
      if (handshake) begin
        valid_q    <= 1'b1;
        tag_q      <= opc_tag_i[grant_idx];
        dst_q      <= opc_dst_i[grant_idx];
        operands_q <= opc_operands_i[grant_idx];
        src_q      <= grant_idx;
        rr_q       <= rr_d;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign eu_valid_o    = valid_q;
  assign eu_tag_o      = tag_q;
  assign eu_dst_o      = dst_q;
  assign eu_operands_o = operands_q;
  assign eu_src_o      = src_q;

  a_ready_onehot0 : assert property (@(posedge clk_i) $onehot0(opc_ready_o));

  a_payload_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    eu_valid_o && !eu_ready_i |=>
      $stable(eu_tag_o) && $stable(eu_dst_o) && $stable(eu_operands_o) && $stable(eu_src_o));

  a_valid_held : assert property (@(posedge clk_i) disable iff (rst_i)
    eu_valid_o && !eu_ready_i && !clr_i |=> eu_valid_o);

endmodule

// File: tb/tb_eu_dispatch_arbiter.sv
// Self-checking bench: directed vector table, fairness run and randomized traffic
// compared against a transaction-level reference model.
module tb_eu_dispatch_arbiter;

  localparam int N   = 4;
  localparam int RW  = 32;
  localparam int WW  = 4;
  localparam int OPS = 2;

  typedef logic [7:0]       tag_t;
  typedef logic [4:0]       dst_t;
  typedef logic [RW*WW-1:0] wd_t;

  logic                      clk = 1'b0;
  logic                      rst, clr;
  logic [N-1:0]              opc_valid, opc_ready;
  tag_t [N-1:0]              opc_tag;
  dst_t [N-1:0]              opc_dst;
  wd_t  [N-1:0][OPS-1:0]     opc_operands;
  logic                      eu_valid, eu_ready;
  tag_t                      eu_tag;
  dst_t                      eu_dst;
  wd_t  [OPS-1:0]            eu_operands;
  logic [1:0]                eu_src;

  always #5 clk = ~clk;

  eu_dispatch_arbiter #(
    .NumCollectors  (N),
    .RegWidth       (RW),
    .WarpWidth      (WW),
    .OperandsPerInst(OPS),
    .iid_t          (tag_t),
    .reg_idx_t      (dst_t)
  ) u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clr_i         (clr),
    .opc_valid_i   (opc_valid),
    .opc_ready_o   (opc_ready),
    .opc_tag_i     (opc_tag),
    .opc_dst_i     (opc_dst),
    .opc_operands_i(opc_operands),
    .eu_valid_o    (eu_valid),
    .eu_ready_i    (eu_ready),
    .eu_tag_o      (eu_tag),
    .eu_dst_o      (eu_dst),
    .eu_operands_o (eu_operands),
    .eu_src_o      (eu_src)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: the held instruction plus the next collector to favour.
  logic           m_valid = 1'b0;
  tag_t           m_tag   = '0;
  dst_t           m_dst   = '0;
  wd_t [OPS-1:0]  m_ops   = '0;
  int             m_src   = 0;
  int             m_rr    = 0;
  logic [N-1:0]   ready_seen;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Who the spec says gets the stage this cycle, or -1.
  function automatic int model_grant();
    if (rst || clr || (m_valid && !eu_ready)) return -1;
    for (int k = 0; k < N; k++) begin
      if (opc_valid[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_update(input int g);
    if (rst) begin
      m_valid = 1'b0; m_tag = '0; m_dst = '0; m_ops = '0; m_src = 0; m_rr = 0;
    end else if (clr) begin
      m_valid = 1'b0;
    end else if (!m_valid || eu_ready) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_tag   = opc_tag[g];
        m_dst   = opc_dst[g];
        m_ops   = opc_operands[g];
        m_src   = g;
        m_rr    = (g + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  // One clock: check combinational ready mid-cycle, then registered outputs after the edge.
  task automatic cycle();
    int g;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    g = model_grant();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    ready_seen = opc_ready;
    chk("opc_ready", 256'(opc_ready), 256'(exp_ready));
    @(posedge clk);
    model_update(g);
    #1;
    chk("eu_valid", 256'(eu_valid), 256'(m_valid));
    chk("eu_tag", 256'(eu_tag), 256'(m_tag));
    chk("eu_dst", 256'(eu_dst), 256'(m_dst));
    chk("eu_operands", 256'(eu_operands), 256'(m_ops));
    chk("eu_src", 256'(eu_src), 256'(m_src));
  endtask

  typedef struct {
    logic       rst;
    logic       clr;
    logic [3:0] valid;
    logic       ready;
    logic [3:0] exp_ready;
    logic       exp_valid;
    logic [1:0] exp_src;
    tag_t       exp_tag;
  } vec_t;

  vec_t vecs[23];
  int   src_cnt[N];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 8'h0A};
    vecs[3]  = '{1'b0, 1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 8'h0B};
    vecs[4]  = '{1'b0, 1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 8'h0C};
    vecs[5]  = '{1'b0, 1'b0, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 8'h0D};
    vecs[6]  = '{1'b0, 1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 8'h0A};
    vecs[7]  = '{1'b0, 1'b0, 4'h4, 1'b1, 4'h4, 1'b1, 2'd2, 8'h0C};
    vecs[8]  = '{1'b0, 1'b0, 4'hA, 1'b1, 4'h8, 1'b1, 2'd3, 8'h0D};
    vecs[9]  = '{1'b0, 1'b0, 4'h2, 1'b1, 4'h2, 1'b1, 2'd1, 8'h0B};
    for (int i = 10; i < 15; i++) vecs[i] = '{1'b0, 1'b0, 4'h3, 1'b0, 4'h0, 1'b1, 2'd1, 8'h0B};
    vecs[15] = '{1'b0, 1'b0, 4'h3, 1'b1, 4'h1, 1'b1, 2'd0, 8'h0A};
    vecs[16] = '{1'b0, 1'b1, 4'h1, 1'b0, 4'h0, 1'b0, 2'd0, 8'h0A};
    vecs[17] = '{1'b0, 1'b0, 4'h1, 1'b0, 4'h1, 1'b1, 2'd0, 8'h0A};
    vecs[18] = '{1'b0, 1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 8'h0B};
    vecs[19] = '{1'b1, 1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 8'h00};
    vecs[20] = '{1'b0, 1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 8'h0A};
    vecs[21] = '{1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 8'h0A};
    vecs[22] = '{1'b0, 1'b0, 4'h8, 1'b0, 4'h8, 1'b1, 2'd3, 8'h0D};

    rst = 1'b1; clr = 1'b0; opc_valid = '0; eu_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      opc_tag[i] = tag_t'(8'h0A + i);
      opc_dst[i] = dst_t'(i + 1);
      for (int j = 0; j < OPS; j++) opc_operands[i][j] = {WW{32'(i * 16 + j + 1)}};
    end
    cycle();
    cycle();

    foreach (vecs[v]) begin
      rst = vecs[v].rst; clr = vecs[v].clr; opc_valid = vecs[v].valid; eu_ready = vecs[v].ready;
      cycle();
      chk($sformatf("vec%0d_ready", v), 256'(ready_seen), 256'(vecs[v].exp_ready));
      chk($sformatf("vec%0d_valid", v), 256'(eu_valid), 256'(vecs[v].exp_valid));
      chk($sformatf("vec%0d_src", v), 256'(eu_src), 256'(vecs[v].exp_src));
      chk($sformatf("vec%0d_tag", v), 256'(eu_tag), 256'(vecs[v].exp_tag));
    end

    // Fairness: all collectors valid, EU always ready, 40 accepts.
    rst = 1'b0; clr = 1'b0; opc_valid = '1; eu_ready = 1'b1;
    for (int i = 0; i < N; i++) src_cnt[i] = 0;
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (eu_valid) src_cnt[eu_src]++;
    end
    for (int i = 0; i < N; i++) chk($sformatf("fair_cnt%0d", i), 256'(src_cnt[i]), 256'(10));

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      clr       = ($urandom_range(0, 19) == 0);
      eu_ready  = ($urandom_range(0, 9) < 7);
      opc_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        opc_tag[i] = tag_t'($urandom);
        opc_dst[i] = dst_t'($urandom);
        for (int j = 0; j < OPS; j++)
          for (int w = 0; w < WW; w++) opc_operands[i][j][w*32 +: 32] = $urandom;
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
